word_unloader: RTL and testbench

Parallel-to-serial reader for a word held in a load-enabled register. It captures a size-bit word on a load strobe, then drains it one bit per accepted transfer over a valid/ready serial handshake. It signals completion with a one-cycle done pulse. It is the read-out counterpart of the team's parallel-load register and sits between a register stage and any bit-serial consumer.

---
 rtl/word_unloader.sv | 81 ++++++++
 tb/tb_word_unloader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/word_unloader.sv
// Parallel-to-serial word reader: captures a word on ld, drains it bit by bit
// over a valid/ready handshake, then emits a one-cycle done pulse.
module word_unloader #(
    parameter int unsigned size      = 3,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld,
    input  logic [size-1:0] inputData,
    output logic            busy,
    output logic            serOut,
    output logic            serValid,
    input  logic            serReady,
    output logic            done
);

    localparam int unsigned CW = (size > 1) ? $clog2(size) : 1;
    localparam logic [CW-1:0] LAST = CW'(size - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [size-1:0] shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ld) begin
                    shreg_d = inputData;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (valid_q && serReady) begin
                    shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flags are registered from the next state so serValid never depends on serReady combinationally.
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == SHIFT);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign serValid = valid_q;
    assign done     = done_q;
    assign serOut   = valid_q & (MSB_FIRST ? shreg_q[size-1] : shreg_q[0]);

endmodule

// File: tb/tb_word_unloader.sv
// Bench for word_unloader: three configurations checked against a queue-based
// transaction model, plus table vectors and hand-written corner sequences.
module tb_word_unloader;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ld, rdy, busy, so, sv, dn;
    logic [31:0] din [3];

    localparam int unsigned SZ  [3] = '{3, 8, 1};
    localparam bit          MSB [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    word_unloader #(.size(3), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .ld(ld[0]), .inputData(din[0][2:0]),
        .busy(busy[0]), .serOut(so[0]), .serValid(sv[0]), .serReady(rdy[0]), .done(dn[0]));
    word_unloader #(.size(8), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .ld(ld[1]), .inputData(din[1][7:0]),
        .busy(busy[1]), .serOut(so[1]), .serValid(sv[1]), .serReady(rdy[1]), .done(dn[1]));
    word_unloader #(.size(1), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst(rst), .ld(ld[2]), .inputData(din[2][0:0]),
        .busy(busy[2]), .serOut(so[2]), .serValid(sv[2]), .serReady(rdy[2]), .done(dn[2]));

    // Model: queue of bits still to be delivered, plus a pending done flag.
    bit          mq [3][$];
    bit          md [3];
    int unsigned nrun = 0;
    int unsigned nfail = 0;

    typedef struct {
        logic       ld;
        logic [2:0] din;
        logic       rdy;
        logic [3:0] exp;   // {busy, serOut, serValid, done}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic l, logic [2:0] d, logic r, logic [3:0] e);
        vec_t v;
        v.ld = l; v.din = d; v.rdy = r; v.exp = e;
        return v;
    endfunction

    function automatic logic [3:0] outs(int i);
        return {busy[i], so[i], sv[i], dn[i]};
    endfunction

    task automatic chk(string name, logic [3:0] got, logic [3:0] exp);
        nrun++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b (busy,serOut,serValid,done) at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            md[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                mq[i].delete();
                md[i] = 1'b0;
            end else if (md[i]) begin
                md[i] = 1'b0;
            end else if (mq[i].size() != 0) begin
                if (rdy[i]) begin
                    void'(mq[i].pop_front());
                    if (mq[i].size() == 0) md[i] = 1'b1;
                end
            end else if (ld[i]) begin
                for (int k = 0; k < int'(SZ[i]); k++)
                    mq[i].push_back(din[i][MSB[i] ? (int'(SZ[i]) - 1 - k) : k]);
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            bit ev, eo;
            ev = (mq[i].size() != 0);
            eo = ev ? mq[i][0] : 1'b0;
            chk($sformatf("model[%0d]", i), outs(i), {ev | md[i], eo, ev, md[i]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        ld = '0;
        rdy = '1;
        for (int i = 0; i < 3; i++) din[i] = '0;
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b0;
        ld = '0;
        rdy = '0;
        for (int i = 0; i < 3; i++) din[i] = '0;
        model_clear();
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("reset[%0d]", i), outs(i), 4'b0000);
        step();
        rst = 1'b1;
        idle_inputs();
        step();

        // Instance 0 vectors: baseline, stall, ld while busy, all-zero word.
        tbl.push_back(mk(1'b1, 3'b101, 1'b1, 4'b1110));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b1010));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b1110));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b1001));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b0000));
        tbl.push_back(mk(1'b1, 3'b101, 1'b1, 4'b1110));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b1010));
        tbl.push_back(mk(1'b0, 3'b000, 1'b0, 4'b1010));
        tbl.push_back(mk(1'b0, 3'b000, 1'b0, 4'b1010));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b1110));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b1001));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b0000));
        tbl.push_back(mk(1'b1, 3'b101, 1'b1, 4'b1110));
        tbl.push_back(mk(1'b1, 3'b010, 1'b1, 4'b1010));
        tbl.push_back(mk(1'b1, 3'b010, 1'b1, 4'b1110));
        tbl.push_back(mk(1'b1, 3'b010, 1'b1, 4'b1001));
        tbl.push_back(mk(1'b1, 3'b010, 1'b1, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b0000));
        tbl.push_back(mk(1'b1, 3'b000, 1'b1, 4'b1010));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b1010));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b1010));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b1001));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 4'b0000));
        for (int n = 0; n < tbl.size(); n++) begin
            ld[0] = tbl[n].ld;
            din[0] = {29'd0, tbl[n].din};
            rdy[0] = tbl[n].rdy;
            step();
            chk($sformatf("vec[%0d]", n), outs(0), tbl[n].exp);
        end
        idle_inputs();

        // Asynchronous reset after the first bit of 3'b110, then reload 3'b011.
        ld[0] = 1'b1; din[0] = 32'd6;
        step();
        ld[0] = 1'b0;
        step();
        chk("pre_abort", outs(0), 4'b1110);
        #2 rst = 1'b0;
        #1;
        chk("async_abort", outs(0), 4'b0000);
        model_clear();
        step();
        rst = 1'b1;
        step();
        chk("no_done_after_abort", outs(0), 4'b0000);
        ld[0] = 1'b1; din[0] = 32'd3;
        step();
        chk("reload_bit0", outs(0), 4'b1010);
        ld[0] = 1'b0;
        step();
        chk("reload_bit1", outs(0), 4'b1110);
        step();
        chk("reload_bit2", outs(0), 4'b1110);
        step();
        chk("reload_done", outs(0), 4'b1001);
        step();

        // size=8 LSB-first 8'hA5: eight bits then done on the 9th edge.
        w = 8'hA5;
        ld[1] = 1'b1; din[1] = 32'hA5;
        for (int k = 0; k < 8; k++) begin
            step();
            ld[1] = 1'b0;
            chk($sformatf("a5_bit%0d", k), outs(1), {1'b1, w[k], 1'b1, 1'b0});
        end
        step();
        chk("a5_done", outs(1), 4'b1001);
        step();

        // size=1 with serReady toggling.
        ld[2] = 1'b1; din[2] = 32'd1; rdy[2] = 1'b0;
        step();
        chk("s1_load", outs(2), 4'b1110);
        ld[2] = 1'b0;
        step();
        chk("s1_stall", outs(2), 4'b1110);
        rdy[2] = 1'b1;
        step();
        chk("s1_done", outs(2), 4'b1001);
        rdy[2] = 1'b0;
        step();
        chk("s1_idle", outs(2), 4'b0000);

        // Random traffic with occasional asynchronous aborts.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 3; i++) begin
                ld[i] = ($urandom_range(3) == 0);
                din[i] = $urandom;
                rdy[i] = ($urandom_range(2) != 0);
            end
            if (c % 200 == 199) begin
                #1 rst = 1'b0;
                #1;
                for (int i = 0; i < 3; i++) chk($sformatf("rand_abort[%0d]", i), outs(i), 4'b0000);
                model_clear();
                #1 rst = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
